mc_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the 8-bit MIPS datapath.
- Sits directly upstream of the ALU. Accepts 16-bit instructions from instruction fetch over a valid/ready handshake.
- Sequences each instruction through decode/execute/memory/writeback. Drives the 3-bit ALU control, register-file addresses/enables, data-memory strobes and PC update.
- Consumes the ALU zero flag for branches.

---
 rtl/mc_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the 8-bit MIPS datapath: fetch handshake, decode, execute,
// memory and writeback sequencing with registered ALU controls.
module mc_ctrl_fsm #(
  parameter int unsigned IMM_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic [2:0]  alu_control,
  output logic        alu_src_imm,
  output logic [7:0]  imm_out,
  output logic [2:0]  rf_raddr0,
  output logic [2:0]  rf_raddr1,
  output logic [2:0]  rf_waddr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        pc_en,
  output logic        pc_branch,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecute, StMem, StWriteback, StHalt
  } state_e;

  localparam logic [3:0] OpAddi = 4'd8;
  localparam logic [3:0] OpBeqz = 4'd9;
  localparam logic [3:0] OpLw   = 4'd10;
  localparam logic [3:0] OpSw   = 4'd11;
  localparam logic [3:0] OpHalt = 4'd15;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  alu_ctrl_q, alu_ctrl_d;
  logic        alu_src_q, alu_src_d;
  logic        illegal_q, illegal_d;
  logic        fetch_ready;

  logic [3:0] opcode;
  logic [2:0] rd, rs, rt;
  logic       is_rtype, is_illegal, is_lw, is_sw, is_beqz, is_addi, is_halt;

  assign opcode = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs     = ir_q[8:6];
  assign rt     = ir_q[5:3];

  assign is_lw   = (opcode == OpLw);
  assign is_sw   = (opcode == OpSw);
  assign is_beqz = (opcode == OpBeqz);
  assign is_addi = (opcode == OpAddi);
  assign is_halt = (opcode == OpHalt);

  always_comb begin
    is_rtype   = 1'b0;
    is_illegal = 1'b0;
    unique case (opcode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7: is_rtype = 1'b1;
      4'd5, 4'd12, 4'd13, 4'd14:                is_illegal = 1'b1;
      default: ;
    endcase
  end

  assign imm_out   = {{(8 - IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign rf_raddr0 = rs;
  // SW reads its store data from rd on the second read port.
  assign rf_raddr1 = is_sw ? rd : rt;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    illegal_d   = illegal_q;
    fetch_ready = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = 3'd0;
    wb_sel      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_en       = 1'b0;
    pc_branch   = 1'b0;

    unique case (state_q)
      StFetch: begin
        fetch_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_illegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d    = StExecute;
          alu_ctrl_d = is_rtype ? opcode[2:0] : (is_beqz ? 3'b000 : 3'b001);
          alu_src_d  = is_addi | is_lw | is_sw;
        end
      end
      StExecute: begin
        if (is_beqz) begin
          pc_branch = alu_zero;
          pc_en     = ~alu_zero;
          state_d   = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWriteback;
        end
      end
      StMem: begin
        mem_re = is_lw;
        mem_we = is_sw;
        if (mem_ack) begin
          if (is_lw) begin
            state_d = StWriteback;
          end else begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWriteback: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        wb_sel   = is_lw;
        pc_en    = 1'b1;
        state_d  = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // ALU controls stay stable for the whole instruction and clear on the way back to fetch.
    if (state_d == StFetch) begin
      alu_ctrl_d = 3'b000;
      alu_src_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      ir_q       <= 16'h0000;
      alu_ctrl_q <= 3'b000;
      alu_src_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
      illegal_q  <= illegal_d;
    end
  end

  // Ready is forced low while reset is held, even though the state already reads as fetch.
  assign instr_ready = fetch_ready & rst_n;
  assign alu_control = alu_ctrl_q;
  assign alu_src_imm = alu_src_q;
  assign halted      = (state_q == StHalt);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction expectations (latency, pulse counts,
// strobe lengths, decoded fields) are derived from the instruction and the driven inputs.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        alu_zero;
  logic        mem_ack;
  logic [2:0]  alu_control;
  logic        alu_src_imm;
  logic [7:0]  imm_out;
  logic [2:0]  rf_raddr0, rf_raddr1, rf_waddr;
  logic        rf_we, wb_sel, mem_re, mem_we, pc_en, pc_branch, halted, illegal;
  logic [29:0] all_outs;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] cur_ins = 16'h0000;

  logic [3:0] legal_ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd10, 4'd11};

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.IMM_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .mem_ack     (mem_ack),
    .alu_control (alu_control),
    .alu_src_imm (alu_src_imm),
    .imm_out     (imm_out),
    .rf_raddr0   (rf_raddr0),
    .rf_raddr1   (rf_raddr1),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .pc_en       (pc_en),
    .pc_branch   (pc_branch),
    .halted      (halted),
    .illegal     (illegal)
  );

  assign all_outs = {instr_ready, alu_control, alu_src_imm, imm_out, rf_raddr0, rf_raddr1,
                     rf_waddr, rf_we, wb_sel, mem_re, mem_we, pc_en, pc_branch, halted, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (instr %04h): got=%0h expected=%0h", tag, cur_ins, got, exp);
    end
  endtask

  function automatic logic [7:0] sext_imm(input logic [15:0] ins);
    int v;
    v = int'(ins[5:0]);
    if (v >= 32) v = v - 64;
    return 8'(v);
  endfunction

  // Called just after a negedge; leaves the DUT released from reset and idle in fetch.
  task automatic do_reset();
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = 16'hFFFF;
    #1;
    check_eq("rst_outputs_zero", 32'(all_outs), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    #1;
    check_eq("rst_release_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_fetch_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_ir_clear", 32'(rf_raddr0), 32'd0);
    check_eq("rst_not_halted", 32'(halted), 32'd0);
  endtask

  // zmode: 0/1 forces alu_zero in the execute cycle, 2 leaves it random.
  task automatic run_instr(input logic [15:0] ins, input int n_wait, input int zmode);
    logic [3:0] opc;
    bit   is_r, is_addi, is_beq, is_lw, is_sw, z2;
    logic [2:0] exp_alu;
    logic exp_src;
    int   exp_ready, exp_we, exp_pc_cyc, mem_cyc;
    int   ready_cyc, we_cnt, we_cyc, pen_cnt, pbr_cnt, pc_cyc, mre_cnt, mwe_cnt;
    int   alu_bad, inv_bad;
    logic wb_at_we;
    logic [2:0] waddr_at_we;

    cur_ins = ins;
    opc     = ins[15:12];
    is_r    = opc inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    is_addi = (opc == 4'd8);
    is_beq  = (opc == 4'd9);
    is_lw   = (opc == 4'd10);
    is_sw   = (opc == 4'd11);
    exp_alu = is_r ? opc[2:0] : (is_beq ? 3'd0 : 3'd1);
    exp_src = is_addi | is_lw | is_sw;
    mem_cyc = 3 + n_wait;
    if (is_beq) begin
      exp_ready = 3; exp_we = 0; exp_pc_cyc = 2;
    end else if (is_lw) begin
      exp_ready = mem_cyc + 2; exp_we = 1; exp_pc_cyc = mem_cyc + 1;
    end else if (is_sw) begin
      exp_ready = mem_cyc + 1; exp_we = 0; exp_pc_cyc = mem_cyc;
    end else begin
      exp_ready = 4; exp_we = 1; exp_pc_cyc = 3;
    end

    ready_cyc = 0; we_cnt = 0; we_cyc = 0; pen_cnt = 0; pbr_cnt = 0; pc_cyc = 0;
    mre_cnt = 0; mwe_cnt = 0; alu_bad = 0; inv_bad = 0; z2 = 1'b0;
    wb_at_we = 1'b0; waddr_at_we = 3'd0;

    check_eq("accept_ready", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    mem_ack     = 1'($urandom);
    alu_zero    = 1'($urandom);
    @(posedge clk);
    for (int k = 1; k <= exp_ready + 8; k++) begin
      #1;
      instr_valid = (k < exp_ready) ? 1'($urandom) : 1'b0;
      instr       = 16'($urandom);
      if ((is_lw || is_sw) && k >= 3 && k <= mem_cyc) mem_ack = (k == mem_cyc);
      else mem_ack = 1'($urandom);
      alu_zero = (k == 2 && zmode < 2) ? zmode[0] : 1'($urandom);
      if (k == 2) z2 = alu_zero;
      @(negedge clk);
      if (k == 1) begin
        check_eq("dec_raddr0", 32'(rf_raddr0), 32'(ins[8:6]));
        check_eq("dec_raddr1", 32'(rf_raddr1), 32'(is_sw ? ins[11:9] : ins[5:3]));
        check_eq("dec_imm", 32'(imm_out), 32'(sext_imm(ins)));
      end
      if (rf_we) begin
        we_cnt++; we_cyc = k; wb_at_we = wb_sel; waddr_at_we = rf_waddr;
      end
      if (pc_en) begin pen_cnt++; pc_cyc = k; end
      if (pc_branch) begin pbr_cnt++; pc_cyc = k; end
      if (mem_re) mre_cnt++;
      if (mem_we) mwe_cnt++;
      if ((pc_en & pc_branch) | (rf_we & mem_we) | halted | illegal) inv_bad++;
      if (k >= 2 && k < exp_ready && (alu_control !== exp_alu || alu_src_imm !== exp_src))
        alu_bad++;
      if (instr_ready) begin
        ready_cyc = k;
        break;
      end
      @(posedge clk);
    end

    check_eq("ready_cycle", 32'(ready_cyc), 32'(exp_ready));
    check_eq("rf_we_count", 32'(we_cnt), 32'(exp_we));
    if (exp_we == 1) begin
      check_eq("rf_we_cycle", 32'(we_cyc), 32'(exp_ready - 1));
      check_eq("wb_sel", 32'(wb_at_we), 32'(is_lw));
      check_eq("rf_waddr", 32'(waddr_at_we), 32'(ins[11:9]));
    end
    check_eq("pc_cycle", 32'(pc_cyc), 32'(exp_pc_cyc));
    check_eq("pc_en_count", 32'(pen_cnt), 32'((is_beq && z2) ? 0 : 1));
    check_eq("pc_branch_count", 32'(pbr_cnt), 32'((is_beq && z2) ? 1 : 0));
    check_eq("mem_re_cycles", 32'(mre_cnt), 32'(is_lw ? n_wait + 1 : 0));
    check_eq("mem_we_cycles", 32'(mwe_cnt), 32'(is_sw ? n_wait + 1 : 0));
    check_eq("alu_ctrl_stable", 32'(alu_bad), 32'd0);
    check_eq("invariants", 32'(inv_bad), 32'd0);
  endtask

  task automatic run_halt(input logic [15:0] ins, input bit exp_ill);
    int bad;
    bad     = 0;
    cur_ins = ins;
    check_eq("halt_accept_ready", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      instr_valid = 1'b1;
      instr       = 16'($urandom);
      mem_ack     = 1'($urandom);
      alu_zero    = 1'($urandom);
      @(negedge clk);
      if (k == 1) check_eq("halt_dec_raddr0", 32'(rf_raddr0), 32'(ins[8:6]));
      if (instr_ready | rf_we | mem_re | mem_we | pc_en | pc_branch) bad++;
      if (k >= 2 && (halted !== 1'b1 || illegal !== exp_ill)) bad++;
      if (k < 6) @(posedge clk);
    end
    check_eq("halted", 32'(halted), 32'd1);
    check_eq("illegal", 32'(illegal), 32'(exp_ill));
    check_eq("halt_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_zero    = 1'b0;
    mem_ack     = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(16'h1650, 0, 2);
    run_instr(16'h847E, 0, 2);
    run_instr(16'h907E, 0, 1);
    run_instr(16'h907E, 0, 0);
    run_instr(16'hA2C5, 3, 2);
    run_instr(16'hB2C5, 3, 2);
    run_instr(16'hA4BF, 0, 2);

    repeat (40) begin
      op = legal_ops[$urandom_range(0, 10)];
      run_instr({op, 12'($urandom)}, int'($urandom_range(0, 4)), 2);
    end

    run_halt(16'h5000, 1'b1);
    do_reset();
    run_halt(16'hF000, 1'b0);
    do_reset();
    for (int o = 12; o <= 14; o++) begin
      run_halt({4'(o), 12'($urandom)}, 1'b1);
      do_reset();
    end

    // Reset while a load is stalled in the memory phase.
    cur_ins = 16'hA2C5;
    check_eq("mid_mem_accept", 32'(instr_ready), 32'd1);
    instr       = 16'hA2C5;
    instr_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      #1;
      instr_valid = 1'b0;
      mem_ack     = 1'b0;
      alu_zero    = 1'($urandom);
      @(negedge clk);
      if (k < 4) @(posedge clk);
    end
    check_eq("mid_mem_re", 32'(mem_re), 32'd1);
    do_reset();
    run_instr(16'h1650, 0, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
